stack_lifo_param: RTL



---
 rtl/stack_pkg.sv | 21 ++
 rtl/stack_ptr_ctrl.sv | 107 ++++++++++
 rtl/stack_lifo_param.sv | 72 +++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared command encoding and modular pointer helper for the parametrised LIFO stack.
package stack_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_POP  = 2'b01,
    CMD_PUSH = 2'b10,
    CMD_GET  = 2'b11
  } stack_cmd_e;

  // (ptr-1-k) mod depth. The inputs are bounded by ptr < depth and
  // k < 2*depth, so at most two corrections are needed.
  function automatic int wrap_dec(input int ptr, input int k, input int depth);
    int v;
    v = ptr - 1 - k;
    if (v < 0) v += depth;
    if (v < 0) v += depth;
    return v;
  endfunction

endpackage

// File: rtl/stack_ptr_ctrl.sv
// Top-pointer / occupancy controller: legality decode, ERROR strobe, memory addressing.
// Build option: STACK_WRAP_EN makes PUSH-when-full overwrite the oldest entry.
module stack_ptr_ctrl #(
  parameter int DEPTH = 5,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cmd_i,
  input  logic [IDX_W-1:0] index_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             error_o,
  output logic             we_o,
  output logic [IDX_W-1:0] waddr_o,
  output logic             rd_en_o,
  output logic [IDX_W-1:0] raddr_o
);
  import stack_pkg::*;

  stack_cmd_e       cmd;
  logic [IDX_W-1:0] tp_q, tp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             error_q, error_d;
  logic [IDX_W-1:0] tp_inc, tp_dec;
  logic [IDX_W-1:0] rd_k;
  logic             full, empty, get_ok;

  assign cmd    = stack_cmd_e'(cmd_i);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign get_ok = (CNT_W'(index_i) < count_q);

  // Wrap at DEPTH rather than at 2^IDX_W so non-power-of-two depths work.
  assign tp_inc = (tp_q == IDX_W'(DEPTH - 1)) ? '0 : tp_q + 1'b1;
  assign tp_dec = IDX_W'(wrap_dec(int'(tp_q), 0, DEPTH));

  // NOTE: every always_comb output gets a default first, otherwise a
  // branch that skips an assignment infers a latch.
  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    error_d = 1'b0;
    we_o    = 1'b0;
    rd_en_o = 1'b0;
    rd_k    = '0;
    case (cmd)
      CMD_PUSH: begin
        if (!full) begin
          we_o    = 1'b1;
          tp_d    = tp_inc;
          count_d = count_q + CNT_W'(1);
        end else begin
`ifdef STACK_WRAP_EN
          we_o = 1'b1;
          tp_d = tp_inc;
`else
          error_d = 1'b1;
`endif
        end
      end
      CMD_POP: begin
        if (!empty) begin
          rd_en_o = 1'b1;
          tp_d    = tp_dec;
          count_d = count_q - CNT_W'(1);
        end else begin
          error_d = 1'b1;
        end
      end
      CMD_GET: begin
        if (get_ok) begin
          rd_en_o = 1'b1;
          rd_k    = index_i;
        end else begin
          error_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign waddr_o = tp_q;
  assign raddr_o = IDX_W'(wrap_dec(int'(tp_q), int'(rd_k), DEPTH));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q    <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = full;
  assign empty_o = empty;
  assign error_o = error_q;

endmodule

// File: rtl/stack_lifo_param.sv
// Parametrised LIFO stack: storage array plus registered read port with valid strobe.
// Build option: STACK_WRAP_EN (ring-history overwrite on PUSH when full).
module stack_lifo_param #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       COMMAND,
  input  logic [IDX_W-1:0] INDEX,
  input  logic [WIDTH-1:0] I_DATA,
  output logic [WIDTH-1:0] O_DATA,
  output logic             O_VALID,
  output logic             FULL,
  output logic             EMPTY,
  output logic [CNT_W-1:0] COUNT,
  output logic             ERROR
);
  import stack_pkg::*;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] o_data_q;
  logic             o_valid_q;
  logic             we, rd_en;
  logic [IDX_W-1:0] waddr, raddr;

  stack_ptr_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_ptr_ctrl (
    .clk     (CLK),
    .rst_n   (RESET),
    .cmd_i   (COMMAND),
    .index_i (INDEX),
    .count_o (COUNT),
    .full_o  (FULL),
    .empty_o (EMPTY),
    .error_o (ERROR),
    .we_o    (we),
    .waddr_o (waddr),
    .rd_en_o (rd_en),
    .raddr_o (raddr)
  );

  // NOTE: the array is reset because stale contents must never be readable
  // after reset; this costs flops instead of a RAM macro.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= I_DATA;
    end
  end

  // Read data holds on anything but a successful POP/GET.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      o_valid_q <= rd_en;
      if (rd_en) o_data_q <= mem_q[raddr];
    end
  end

  assign O_DATA  = o_data_q;
  assign O_VALID = o_valid_q;

endmodule
